// File: rtl/rv_enc_pkg.sv
// RV32I encoder package: opcode constants, field-format and FSM state enums.
package rv_enc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_LOAD = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_IALU = 3'd4
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational RV32I field-to-word packer.
// ENC_RANGE_CHECK_EN: when defined, flags immediates that do not fit their format.
module rv_instr_pack
  import rv_enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        fmt_valid,
  output logic        imm_ok
);

  // Pack fields by format; unknown formats yield a zero word and fmt_valid=0.
  always_comb begin
    word      = '0;
    fmt_valid = 1'b1;
    case (fmt)
      FMT_R:    word = {funct7, rs2, rs1, funct3, rd, OP_R};
      FMT_LOAD: word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      FMT_IALU: word = {imm[11:0], rs1, funct3, rd, OP_IMM};
      FMT_S:    word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
      FMT_B:    word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
      default:  fmt_valid = 1'b0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // 12-bit immediates must sign-extend cleanly; branch offsets must be even.
  always_comb begin
    imm_ok = 1'b1;
    case (fmt)
      FMT_LOAD, FMT_IALU, FMT_S: imm_ok = (imm[12] == imm[11]);
      FMT_B:                     imm_ok = ~imm[0];
      default:                   imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and program loader: accepts field bundles over
// valid/ready and writes encoded words to consecutive instruction-memory slots.
// ENC_RANGE_CHECK_EN: when defined, out-of-range immediates are rejected (see rv_instr_pack).
module instr_encoder_loader
  import rv_enc_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [12:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  state_e      state, state_nxt;
  logic [31:0] word;
  logic        fmt_valid;
  logic        imm_ok;
  logic        accept;
  logic        good;

  rv_instr_pack u_pack (
    .fmt       (fmt),
    .funct3    (funct3),
    .funct7    (funct7),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .word      (word),
    .fmt_valid (fmt_valid),
    .imm_ok    (imm_ok)
  );

  // Region is exhausted once 2^ADDR_W words have been written (count MSB).
  assign full     = count[ADDR_W];
  assign in_ready = (state == ST_ARMED) && !full;
  assign accept   = in_valid && in_ready;
  assign good     = fmt_valid && imm_ok;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and write strobe; start overrides everything, aborting a pending write.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    case (state)
      ST_IDLE:  state_nxt = ST_IDLE;
      ST_ARMED: if (accept && good) state_nxt = ST_WRITE;
      ST_WRITE: begin
        mem_we    = 1'b1;
        state_nxt = ST_ARMED;
      end
      default:  state_nxt = ST_IDLE;
    endcase
    if (start) begin
      state_nxt = ST_ARMED;
      mem_we    = 1'b0;
    end
  end

  // Address, count, data and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else if (start) begin
      mem_addr <= base_addr;
      count    <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        if (good) mem_wdata <= word;
        else      err       <= 1'b1;
      end
      if (state == ST_WRITE) begin
        mem_addr <= mem_addr + ADDR_W'(1);
        count    <= count + (ADDR_W + 1)'(1);
      end
    end
  end

endmodule
